// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the MIPS boot controller: the sequencer state
// encoding, the CAUSE codes reported when a sequence ends, and the default
// sizing of the instruction memory and the run-cycle counter.

package mips_ctrl_pkg;

    // Default instruction-memory depth (words) and run-counter width (bits).
    localparam int DEF_MAX_WORDS = 64;
    localparam int DEF_CNT_W     = 16;

    // Sequencer states.
    //   ST_IDLE  : CPU held in reset, waiting for START.
    //   ST_LOAD  : accepting program words from the loader.
    //   ST_FLUSH : one cycle so the final instruction write lands under reset.
    //   ST_RUN   : CPU released from reset, cycles counted.
    //   ST_FIN   : sequence ended, results held until START or ABORT.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Reason a sequence ended.
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET   = 2'b01;
    localparam logic [1:0] CAUSE_PC_HALT  = 2'b10;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b11;

endpackage

// File: rtl/mips_run_counter.sv
// mips_run_counter
// Saturating run-cycle counter with a captured budget.
//
// Ports
//   clk_i     in   1      clock, rising edge
//   rst_ni    in   1      asynchronous active-low reset
//   clr_i     in   1      clear the count and capture budget_i
//   en_i      in   1      count this cycle (saturates at all-ones)
//   budget_i  in   CNT_W  budget sampled when clr_i is high; 0 = unlimited
//   count_o   out  CNT_W  registered cycle count
//   match_o   out  1      this cycle is the last one of a non-zero budget
//                         (count_o + 1 == captured budget)

module mips_run_counter
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] budget_i,
    output logic [CNT_W-1:0] count_o,
    output logic             match_o
);

    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic [CNT_W:0]   count_inc;

    // One bit wider so the compare against the budget never wraps when the
    // count sits at all-ones.
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        count_d  = count_q;
        budget_d = budget_q;
        if (clr_i) begin
            count_d  = '0;
            budget_d = budget_i;
        end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            budget_q <= '0;
        end else begin
            count_q  <= count_d;
            budget_q <= budget_d;
        end
    end

    assign count_o = count_q;
    assign match_o = (budget_q != '0) && (count_inc == {1'b0, budget_q});

endmodule

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl
// Loads a program into a MIPS CPU's instruction memory through its write
// port while holding the CPU in reset, then releases the CPU for a bounded
// run and reports why the run ended.
//
// Ports
//   CLK         in   1       clock, rising edge
//   RST         in   1       asynchronous active-low reset
//   START       in   1       begin load+run (ignored while BUSY)
//   ABORT       in   1       return to IDLE next cycle (highest priority)
//   LD_VALID    in   1       loader word valid
//   LD_DATA     in   32      loader instruction word
//   LD_LAST     in   1       final word of the program
//   LD_READY    out  1       a loader word is accepted this cycle
//   RUN_CYCLES  in   CNT_W   run budget captured on START; 0 = unlimited
//   HALT_EN     in   1       enable PC-match halt
//   HALT_PC     in   32      PC-match halt address
//   CPU_PC      in   32      current CPU PC
//   W_Ins       out  32      instruction word to the CPU write port
//   WE          out  1       CPU instruction-write strobe
//   CPU_RST     out  1       active-high CPU reset
//   BUSY        out  1       LOAD, FLUSH or RUN in progress
//   DONE        out  1       sequence finished (sticky in FIN)
//   CAUSE       out  2       end reason: none / budget / PC halt / overflow
//   WORDS       out  log2(MAX_WORDS)+1  words loaded
//   CYCLES      out  CNT_W   CPU cycles run
//   STATE_DBG   out  3       current sequencer state
//
// Handshake: a loader word transfers on a rising edge where LD_VALID and
// LD_READY are both high; LD_DATA/LD_LAST are only looked at on that edge.
// LD_READY is registered, so it cannot react to LD_VALID in the same cycle.
//
// All outputs are registered. The per-state outputs are computed from the
// next state, so they line up with the state register.

module mips_boot_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic                       LD_VALID,
    input  logic [31:0]                LD_DATA,
    input  logic                       LD_LAST,
    output logic                       LD_READY,
    input  logic [CNT_W-1:0]           RUN_CYCLES,
    input  logic                       HALT_EN,
    input  logic [31:0]                HALT_PC,
    input  logic [31:0]                CPU_PC,
    output logic [31:0]                W_Ins,
    output logic                       WE,
    output logic                       CPU_RST,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [1:0]                 CAUSE,
    output logic [$clog2(MAX_WORDS):0] WORDS,
    output logic [CNT_W-1:0]           CYCLES,
    output state_e                     STATE_DBG
);

    localparam int WW = $clog2(MAX_WORDS) + 1;

    state_e          state_q,    state_d;
    logic            we_q,       we_d;
    logic [31:0]     w_ins_q,    w_ins_d;
    logic [WW-1:0]   words_q,    words_d;
    logic [1:0]      cause_q,    cause_d;
    logic            ld_ready_q, ld_ready_d;
    logic            cpu_rst_q,  cpu_rst_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;

    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_match;
    logic            xfer;
    logic            halt_hit;
    logic [WW-1:0]   words_inc;

    assign xfer      = LD_VALID && ld_ready_q;
    assign halt_hit  = HALT_EN && (CPU_PC == HALT_PC);
    assign words_inc = words_q + WW'(1);

    mips_run_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .budget_i (RUN_CYCLES),
        .count_o  (CYCLES),
        .match_o  (cnt_match)
    );

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        w_ins_d = w_ins_q;
        words_d = words_q;
        cause_d = cause_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (ABORT) begin
            // Counters keep their values so software can see how far it got.
            state_d = ST_IDLE;
            cause_d = CAUSE_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        state_d = ST_LOAD;
                        words_d = '0;
                        cause_d = CAUSE_NONE;
                        cnt_clr = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        we_d    = 1'b1;
                        w_ins_d = LD_DATA;
                        words_d = words_inc;
                        if (LD_LAST || (words_inc == WW'(MAX_WORDS))) begin
                            state_d = ST_FLUSH;
                            // Memory filled without a LAST marker: the program
                            // is truncated, so it must never be run.
                            if (!LD_LAST) begin
                                cause_d = CAUSE_OVERFLOW;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state_d = (cause_q == CAUSE_OVERFLOW) ? ST_FIN : ST_RUN;
                end
                ST_RUN: begin
                    cnt_en = 1'b1;
                    // PC halt wins over the budget when both hit together.
                    if (halt_hit) begin
                        state_d = ST_FIN;
                        cause_d = CAUSE_PC_HALT;
                    end else if (cnt_match) begin
                        state_d = ST_FIN;
                        cause_d = CAUSE_BUDGET;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ld_ready_d = (state_d == ST_LOAD);
        cpu_rst_d  = (state_d != ST_RUN);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_FLUSH) || (state_d == ST_RUN);
        done_d     = (state_d == ST_FIN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            w_ins_q    <= '0;
            words_q    <= '0;
            cause_q    <= CAUSE_NONE;
            ld_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            w_ins_q    <= w_ins_d;
            words_q    <= words_d;
            cause_q    <= cause_d;
            ld_ready_q <= ld_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign LD_READY  = ld_ready_q;
    assign W_Ins     = w_ins_q;
    assign WE        = we_q;
    assign CPU_RST   = cpu_rst_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CAUSE     = cause_q;
    assign WORDS     = words_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// tb_mips_boot_ctrl
// Self-checking bench for mips_boot_ctrl: a table of directed sequences,
// randomized sequences scored against an arithmetic end-of-run model, and
// hand-written abort / reset / ignored-input sequences.

module tb_mips_boot_ctrl;
    import mips_ctrl_pkg::*;

    localparam int MAX_W = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int INF   = 1 << 20;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST;
    logic          START, ABORT, LD_VALID, LD_LAST, HALT_EN;
    logic [31:0]   LD_DATA, HALT_PC, CPU_PC;
    logic [CW-1:0] RUN_CYCLES;
    logic          LD_READY, WE, CPU_RST, BUSY, DONE;
    logic [31:0]   W_Ins;
    logic [1:0]    CAUSE;
    logic [2:0]    WORDS;
    logic [CW-1:0] CYCLES;
    state_e        STATE_DBG;

    always #5 CLK = ~CLK;

    mips_boot_ctrl #(
        .MAX_WORDS (MAX_W),
        .CNT_W     (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .LD_VALID   (LD_VALID),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
        .LD_READY   (LD_READY),
        .RUN_CYCLES (RUN_CYCLES),
        .HALT_EN    (HALT_EN),
        .HALT_PC    (HALT_PC),
        .CPU_PC     (CPU_PC),
        .W_Ins      (W_Ins),
        .WE         (WE),
        .CPU_RST    (CPU_RST),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CAUSE      (CAUSE),
        .WORDS      (WORDS),
        .CYCLES     (CYCLES),
        .STATE_DBG  (STATE_DBG)
    );

    // Simple CPU: PC held at 0 in reset, advances by 4 every running cycle.
    logic [31:0] pc_q;
    always @(posedge CLK) begin
        if (CPU_RST) pc_q <= 32'h0;
        else         pc_q <= pc_q + 32'd4;
    end
    assign CPU_PC = pc_q;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, we_cnt = 0, first_we = -1, last_we = -1, rst_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        we_cnt = 0; first_we = -1; last_we = -1; rst_low = 0;
    endtask

    // Advance to the next falling edge and score the cycle's write strobe.
    task automatic tick();
        logic [31:0] e;
        @(negedge CLK);
        cyc++;
        if (WE === 1'b1) begin
            we_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'b0, WE}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("w_ins", W_Ins, e);
            end
        end
        if (CPU_RST === 1'b0) rst_low++;
    endtask

    // ---------------- stimulus records ----------------
    typedef struct {
        int          n;          // words to send (ignored without LAST: stream until full)
        bit          with_last;
        int          budget;
        bit          hen;
        logic [31:0] hpc;
        int          exp_cause;
        int          exp_words;
        int          exp_cycles;
        int          exp_run;    // cycles with CPU_RST low
    } vec_t;

    // End-of-run outcome from the rules: PC = 4*(k-1) on run cycle k, so a
    // word-aligned halt address hits on cycle hpc/4+1; the run ends at the
    // earlier of that and the budget, PC halt winning ties.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int h, b, run;
        r = v;
        if (!r.with_last) begin
            r.n = MAX_W; r.exp_cause = 3; r.exp_words = MAX_W;
            r.exp_cycles = 0; r.exp_run = 0;
            return r;
        end
        h = (r.hen && r.hpc[1:0] == 2'b00) ? int'(r.hpc >> 2) + 1 : INF;
        b = (r.budget == 0) ? INF : r.budget;
        if (h <= b) begin r.exp_cause = 2; run = h; end
        else        begin r.exp_cause = 1; run = b; end
        r.exp_words  = r.n;
        r.exp_run    = run;
        r.exp_cycles = (run > CMAX) ? CMAX : run;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_load(input int n, input bit with_last, input bit gaps, output int acc);
        int guard;
        bit fin;
        acc = 0; guard = 0; fin = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        while (!fin && guard < 64) begin
            guard++;
            if (LD_READY && !(gaps && $urandom_range(0, 2) == 0)) begin
                LD_VALID = 1'b1;
                LD_DATA  = $urandom();
                LD_LAST  = with_last && (acc == n - 1);
                exp_q.push_back(LD_DATA);
                acc++;
                fin = with_last ? (acc == n) : (acc == MAX_W);
            end
            tick();
            LD_VALID = 1'b0; LD_LAST = 1'b0;
        end
        check("ld_ready_drop", {31'b0, LD_READY}, 32'd0);
    endtask

    task automatic run_seq(input vec_t v, input bit gaps, input bit noise);
        int acc, guard;
        bit seen_done;
        clear_stats();
        RUN_CYCLES = CW'(v.budget); HALT_EN = v.hen; HALT_PC = v.hpc;
        do_load(v.n, v.with_last, gaps, acc);
        guard = 0; seen_done = 1'b0;
        while (guard < 400) begin
            if (DONE === 1'b1) begin seen_done = 1'b1; break; end
            if (noise) begin
                START    = 1'($urandom_range(0, 1));
                LD_VALID = 1'($urandom_range(0, 1));
            end
            tick(); guard++;
        end
        START = 1'b0; LD_VALID = 1'b0;
        check("done",       {31'b0, DONE},    32'd1);
        check("cause",      {30'b0, CAUSE},   v.exp_cause);
        check("words",      {29'b0, WORDS},   v.exp_words);
        check("cycles",     {24'b0, CYCLES},  v.exp_cycles);
        check("cpu_rst_low", rst_low,         v.exp_run);
        check("we_count",   we_cnt,           acc);
        check("words_sent", acc,              v.exp_words);
        check("busy_fin",   {31'b0, BUSY},    32'd0);
        if (!gaps) check("we_back_to_back", last_we - first_we + 1, acc);
        // Loader activity while finished must be ignored.
        LD_VALID = 1'b1; tick(); LD_VALID = 1'b0; tick();
        check("fin_hold_state", STATE_DBG,    ST_FIN);
        check("fin_hold_words", {29'b0, WORDS}, v.exp_words);
        check("exp_q_empty",  exp_q.size(),   32'd0);
        if (!seen_done) begin
            ABORT = 1'b1; tick(); ABORT = 1'b0;
            exp_q.delete();
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[8];

    initial begin
        vec_t v;
        int acc;

        //         n  last bud hen hpc     cause words cyc run
        tbl[0] = '{3, 1,   5,  0,  32'h0,  1,    3,    5,  5};  // basic budget run
        tbl[1] = '{2, 1,   0,  1,  32'hC,  2,    2,    4,  4};  // PC halt, unlimited budget
        tbl[2] = '{4, 0,   7,  0,  32'h0,  3,    4,    0,  0};  // overflow, never runs
        tbl[3] = '{1, 1,   3,  1,  32'h8,  2,    1,    3,  3};  // tie: PC halt wins
        tbl[4] = '{4, 1,   1,  0,  32'h0,  1,    4,    1,  1};  // full memory with LAST, budget 1
        tbl[5] = '{2, 1,   10, 1,  32'h0,  2,    2,    1,  1};  // halt on first run cycle
        tbl[6] = '{3, 1,   7,  1,  32'h6,  1,    3,    7,  7};  // unaligned halt PC never hits
        tbl[7] = '{1, 1,   9,  1,  32'h20, 2,    1,    9,  9};  // tie at cycle 9

        RST = 1'b0; START = 1'b0; ABORT = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0;
        LD_DATA = '0; HALT_EN = 1'b0; HALT_PC = '0; RUN_CYCLES = '0;

        // Reset values.
        tick(); tick();
        check("rst_state",   STATE_DBG,         ST_IDLE);
        check("rst_cpu_rst", {31'b0, CPU_RST},  32'd1);
        check("rst_we",      {31'b0, WE},       32'd0);
        check("rst_w_ins",   W_Ins,             32'd0);
        check("rst_ready",   {31'b0, LD_READY}, 32'd0);
        check("rst_busy",    {31'b0, BUSY},     32'd0);
        check("rst_done",    {31'b0, DONE},     32'd0);
        check("rst_cause",   {30'b0, CAUSE},    32'd0);
        check("rst_words",   {29'b0, WORDS},    32'd0);
        check("rst_cycles",  {24'b0, CYCLES},   32'd0);

        // Idle after reset: no progress without START, loader ignored.
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'(i % 2); LD_DATA = $urandom(); tick();
        end
        LD_VALID = 1'b0;
        check("idle_hold_state", STATE_DBG,      ST_IDLE);
        check("idle_no_we",      we_cnt,         32'd0);
        check("idle_ready",      {31'b0, LD_READY}, 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) run_seq(tbl[i], 1'b0, (i % 2) == 1);

        // ABORT during LOAD after two words, with a third word offered at the same time.
        clear_stats();
        RUN_CYCLES = 8'd4; HALT_EN = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            LD_VALID = 1'b1; LD_LAST = 1'b0; LD_DATA = $urandom();
            exp_q.push_back(LD_DATA);
            tick();
        end
        LD_VALID = 1'b1; LD_DATA = $urandom(); ABORT = 1'b1;
        tick();
        ABORT = 1'b0; LD_VALID = 1'b0;
        check("abort_state",   STATE_DBG,        ST_IDLE);
        check("abort_we",      {31'b0, WE},      32'd0);
        check("abort_cpu_rst", {31'b0, CPU_RST}, 32'd1);
        check("abort_done",    {31'b0, DONE},    32'd0);
        check("abort_busy",    {31'b0, BUSY},    32'd0);
        check("abort_cause",   {30'b0, CAUSE},   32'd0);
        check("abort_words",   {29'b0, WORDS},   32'd2);
        check("abort_we_cnt",  we_cnt,           32'd2);
        tick(); tick();
        check("abort_no_late_we", we_cnt,        32'd2);
        run_seq(tbl[0], 1'b0, 1'b0);

        // Unlimited run: counter saturates, then ABORT from RUN keeps CYCLES and WORDS.
        clear_stats();
        RUN_CYCLES = '0; HALT_EN = 1'b0;
        do_load(1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 300; i++) tick();
        check("sat_cycles",  {24'b0, CYCLES},  CMAX);
        check("sat_busy",    {31'b0, BUSY},    32'd1);
        check("sat_cpu_rst", {31'b0, CPU_RST}, 32'd0);
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        check("sat_abort_state",  STATE_DBG,       ST_IDLE);
        check("sat_abort_cycles", {24'b0, CYCLES}, CMAX);
        check("sat_abort_words",  {29'b0, WORDS},  32'd1);
        check("sat_abort_done",   {31'b0, DONE},   32'd0);

        // RST low in the middle of RUN.
        clear_stats();
        RUN_CYCLES = '0; HALT_EN = 1'b0;
        do_load(2, 1'b1, 1'b0, acc);
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_running", {31'b0, CPU_RST}, 32'd0);
        RST = 1'b0;
        #1;
        check("mid_rst_state",   STATE_DBG,        ST_IDLE);
        check("mid_rst_we",      {31'b0, WE},      32'd0);
        check("mid_rst_cpu_rst", {31'b0, CPU_RST}, 32'd1);
        check("mid_rst_done",    {31'b0, DONE},    32'd0);
        check("mid_rst_words",   {29'b0, WORDS},   32'd0);
        check("mid_rst_cycles",  {24'b0, CYCLES},  32'd0);
        tick();
        RST = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'(i % 2); tick();
        end
        LD_VALID = 1'b0;
        check("post_rst_state", STATE_DBG, ST_IDLE);
        check("post_rst_no_we", we_cnt,    32'd0);
        run_seq(tbl[3], 1'b0, 1'b0);

        // Randomized sequences against the model.
        for (int k = 0; k < 30; k++) begin
            v.with_last = ($urandom_range(0, 5) != 0);
            v.n         = $urandom_range(1, MAX_W);
            v.budget    = $urandom_range(0, 12);
            v.hen       = 1'($urandom_range(0, 1));
            v.hpc       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                                       : 32'($urandom_range(0, 12) * 4);
            if (v.budget == 0 && !(v.hen && v.hpc[1:0] == 2'b00)) v.budget = $urandom_range(1, 12);
            v = model(v);
            run_seq(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_boot_ctrl.md
MIPS_BOOT_CTRL -- requirements
Module: mips_boot_ctrl

Interface
REQ-001 Parameter: MAX_WORDS, default 64, meaning instruction-memory depth in words (power of two, at most 256).
REQ-002 Parameter: CNT_W, default 16, meaning width of the run-cycle budget and counter.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  level, sampled per cycle; begins load+run sequence.
REQ-006 ABORT  in  1  forces return to IDLE.
REQ-007 LD_VALID  in  1  loader word valid.
REQ-008 LD_DATA  in  32  instruction word.
REQ-009 LD_LAST  in  1  final word of program.
REQ-010 LD_READY  out  1  block accepts a loader word this cycle.
REQ-011 RUN_CYCLES  in  CNT_W  cycle budget, captured on START; 0 = unlimited.
REQ-012 HALT_EN, HALT_PC  in  1, 32  enable and address of PC-match halt.
REQ-013 CPU_PC  in  32  PC from the CPU.
REQ-014 W_Ins  out  32  instruction word to the CPU write port.
REQ-015 WE  out  1  CPU instruction-write strobe.
REQ-016 CPU_RST  out  1  active-high reset to the CPU.
REQ-017 BUSY, DONE  out  1, 1  sequence in progress; sequence finished (sticky until next START or ABORT).
REQ-018 CAUSE  out  2  00 none, 01 budget, 10 PC halt, 11 load overflow.
REQ-019 WORDS  out  log2(MAX_WORDS)+1  words loaded; CYCLES  out  CNT_W  CPU cycles run.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, FLUSH, RUN and FIN; all outputs SHALL be registered.
REQ-021 IDLE: CPU_RST=1, WE=0, LD_READY=0, BUSY=0; START=1 -> LOAD, which clears WORDS, CYCLES, CAUSE and DONE and captures RUN_CYCLES.
REQ-022 LOAD: CPU_RST=1, LD_READY=1, BUSY=1; a word transfers on LD_VALID&LD_READY.
REQ-023 Each transfer SHALL drive W_Ins=LD_DATA with WE=1 for exactly one cycle, starting the cycle after acceptance, and SHALL increment WORDS.
REQ-024 Back-to-back transfers SHALL sustain one word per cycle with WE held high.
REQ-025 A transfer with LD_LAST=1, or the transfer that makes WORDS==MAX_WORDS, SHALL move LOAD -> FLUSH and deassert LD_READY in the following cycle.
REQ-026 A transfer reaching MAX_WORDS with LD_LAST=0 SHALL set CAUSE=11 and go FLUSH -> FIN, skipping RUN.
REQ-027 FLUSH lasts one cycle: the WE of the last word completes with CPU_RST=1; next state is RUN.
REQ-028 RUN: CPU_RST=0 and CYCLES increments every cycle, saturating at all-ones.
REQ-029 RUN -> FIN when CYCLES+1 == captured budget (budget non-zero), so CPU_RST is low for exactly RUN_CYCLES cycles.
REQ-030 RUN -> FIN when HALT_EN=1 and CPU_PC==HALT_PC.
REQ-031 If the budget and PC-halt conditions occur in the same cycle, CAUSE SHALL be 10 (PC halt has priority).
REQ-032 FIN: CPU_RST=1, DONE=1, BUSY=0; CYCLES and WORDS frozen; START -> LOAD.
REQ-033 START while BUSY=1 SHALL be ignored.
REQ-034 ABORT=1 SHALL force IDLE next cycle from any state and drop WE in that same next cycle; CAUSE and DONE are cleared and CYCLES and WORDS retain their values.
REQ-035 ABORT SHALL take priority over START and all transfer events.
REQ-036 LD_VALID in any state other than LOAD SHALL be ignored and produce no WE.

Reset
REQ-037 RST low SHALL immediately force IDLE, CPU_RST=1, WE=0, W_Ins=0, LD_READY=0, BUSY=0, DONE=0, CAUSE=00, WORDS=0 and CYCLES=0.
REQ-038 RST asserted mid-LOAD or mid-RUN SHALL abort with no further WE pulse after release.
REQ-039 After RST deasserts, no state change occurs until START.

Structure
REQ-040 Shared package mips_ctrl_pkg SHALL hold the state enumeration, the CAUSE code constants and the default MAX_WORDS/CNT_W values.
REQ-041 One sub-module, mips_run_counter, SHALL implement the saturating CNT_W counter with clear, enable and budget-match output; everything else is inline.

Verification
REQ-042 RST low, then START with 3 words (LAST on the third), RUN_CYCLES=5 -> three consecutive WE pulses with matching W_Ins; CPU_RST low exactly 5 cycles; DONE=1, CAUSE=01, WORDS=3, CYCLES=5.
REQ-043 HALT_EN=1, HALT_PC=0x0000_000C, budget 0, CPU model PC advances by 4 per cycle -> FIN on the cycle PC==0x0C; CAUSE=10; CYCLES=4.
REQ-044 MAX_WORDS=4, stream 4 words with LD_LAST=0 -> LD_READY drops after the fourth word; CAUSE=11; CPU_RST never deasserts.
REQ-045 Budget 3 with PC reaching HALT_PC on the third run cycle -> CAUSE=10 (priority check).
REQ-046 ABORT during LOAD after 2 words, and separately RST low mid-RUN -> IDLE next cycle (or immediately for RST), WE=0, CPU_RST=1, DONE=0; a subsequent START reloads from WORDS=0.
REQ-047 LD_VALID toggled in IDLE and FIN, plus START pulsed during RUN -> no WE pulses and no state change.
